fifo_skew_sched: RTL

Read-side controller for a bank of per-row input FIFOs feeding the systolic array. On a start command it drains `len` words from each of `ROWS` FIFOs with a diagonal skew: row i starts i cycles after row 0, so operands arrive wavefront-aligned at the array edge. It stalls the whole wavefront when any due FIFO is empty, and signals completion with a one-cycle `done` pulse.

---
 rtl/fifo_sched_pkg.sv | 17 +
 rtl/sched_row_window.sv | 30 +++
 rtl/fifo_skew_sched.sv | 132 +++++++++++++
 3 files changed

// File: rtl/fifo_sched_pkg.sv
// fifo_sched_pkg
// Shared types and constants for the skewed FIFO read scheduler.
//   sched_state_t : controller states IDLE / RUN / DRAIN / DONE
//   STALL_CNT_W   : width of the optional stall cycle counter
// Optional feature macro: FIFO_SCHED_STALL_CNT_EN (see fifo_skew_sched).
package fifo_sched_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } sched_state_t;

  localparam int STALL_CNT_W = 16;

endpackage

// File: rtl/sched_row_window.sv
// sched_row_window
// Decides whether one row lies inside its read window for the current
// wavefront step: row ROW_IDX reads while ROW_IDX <= t < ROW_IDX + len_q.
// Ports:
//   t      in  T_W    wavefront counter
//   len_q  in  LEN_W  latched words-per-row
//   active out 1      row is inside its window (not gated by FSM state)
module sched_row_window
  import fifo_sched_pkg::*;
#(
  parameter int T_W     = 11,
  parameter int LEN_W   = 8,
  parameter int ROW_IDX = 0
) (
  input  logic [T_W-1:0]   t,
  input  logic [LEN_W-1:0] len_q,
  output logic             active
);

  localparam logic [T_W-1:0] ROW_T = T_W'(ROW_IDX);

  logic [T_W-1:0] len_t;
  logic [T_W-1:0] end_t;

  // T_W has headroom over LEN_W, so the window end never wraps.
  assign len_t  = {{(T_W-LEN_W){1'b0}}, len_q};
  assign end_t  = ROW_T + len_t;
  assign active = (t >= ROW_T) && (t < end_t);

endmodule

// File: rtl/fifo_skew_sched.sv
// fifo_skew_sched
// Read-side controller for ROWS per-row input FIFOs feeding a systolic
// array. On start it drains len words from every FIFO, row i starting i
// cycles after row 0, and freezes the whole wavefront whenever a due FIFO
// is empty so the diagonal alignment is kept.
// Ports:
//   clk        in  1      rising-edge clock
//   rst_n      in  1      asynchronous active-low reset
//   start      in  1      command strobe, sampled only in IDLE
//   len        in  LEN_W  words per row, latched with start
//   fifo_empty in  ROWS   per-row FIFO empty flags
//   fifo_rd_en out ROWS   per-row FIFO read enables
//   out_valid  out ROWS   fifo_rd_en delayed by one cycle
//   busy       out 1      high in RUN and DRAIN
//   done       out 1      one-cycle completion pulse
//   stall_cnt  out 16     stall cycle count (only with FIFO_SCHED_STALL_CNT_EN)
// Optional feature macro: FIFO_SCHED_STALL_CNT_EN.
module fifo_skew_sched
  import fifo_sched_pkg::*;
#(
  parameter int ROWS  = 4,
  parameter int LEN_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  input  logic [ROWS-1:0]  fifo_empty,
  output logic [ROWS-1:0]  fifo_rd_en,
  output logic [ROWS-1:0]  out_valid,
  output logic             busy,
  output logic             done
`ifdef FIFO_SCHED_STALL_CNT_EN
  ,
  output logic [STALL_CNT_W-1:0] stall_cnt
`endif
);

  // Enough bits for len + ROWS - 1 with one spare.
  localparam int T_W = LEN_W + $clog2(ROWS) + 1;

  sched_state_t     state_reg, state_next;
  logic [T_W-1:0]   t_reg, t_next;
  logic [LEN_W-1:0] len_q_reg, len_q_next;
  logic [ROWS-1:0]  out_valid_reg;
  logic [ROWS-1:0]  window;
  logic [ROWS-1:0]  active;
  logic [T_W-1:0]   last_t;
  logic             stall;
  logic             last_issue;

  for (genvar gi = 0; gi < ROWS; gi++) begin : g_row
    sched_row_window #(
      .T_W    (T_W),
      .LEN_W  (LEN_W),
      .ROW_IDX(gi)
    ) u_window (
      .t     (t_reg),
      .len_q (len_q_reg),
      .active(window[gi])
    );
  end

  assign active     = (state_reg == RUN) ? window : '0;
  assign stall      = |(active & fifo_empty);
  assign fifo_rd_en = stall ? '0 : active;

  // Step at which the last row issues its last word.
  assign last_t     = {{(T_W-LEN_W){1'b0}}, len_q_reg} + T_W'(ROWS) - T_W'(2);
  assign last_issue = (state_reg == RUN) && !stall && (t_reg == last_t);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      t_reg         <= '0;
      len_q_reg     <= '0;
      out_valid_reg <= '0;
    end else begin
      state_reg     <= state_next;
      t_reg         <= t_next;
      len_q_reg     <= len_q_next;
      out_valid_reg <= fifo_rd_en;
    end
  end

  always_comb begin
    state_next = state_reg;
    t_next     = t_reg;
    len_q_next = len_q_reg;
    case (state_reg)
      IDLE: begin
        if (start) begin
          len_q_next = len;
          t_next     = '0;
          state_next = (len != '0) ? RUN : DONE;
        end
      end
      RUN: begin
        // A stalled cycle holds t so every row slips by the same amount.
        if (!stall) t_next = t_reg + T_W'(1);
        if (last_issue) state_next = DRAIN;
      end
      DRAIN:   state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign out_valid = out_valid_reg;
  assign busy      = (state_reg == RUN) || (state_reg == DRAIN);
  assign done      = (state_reg == DONE);

`ifdef FIFO_SCHED_STALL_CNT_EN
  logic [STALL_CNT_W-1:0] stall_cnt_reg;

  // Cleared by an accepted start, saturating, held after done.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_reg <= '0;
    end else if ((state_reg == IDLE) && start) begin
      stall_cnt_reg <= '0;
    end else if (stall && (stall_cnt_reg != '1)) begin
      stall_cnt_reg <= stall_cnt_reg + STALL_CNT_W'(1);
    end
  end

  assign stall_cnt = stall_cnt_reg;
`else
  // No stall counter in this build.
`endif

endmodule
